led_indicator_bank: RTL
=======================

Name: led_indicator_bank

Overview:
- Multi-channel front-panel LED indicator driver; the successor to the single-channel activity stretcher.
- Each channel turns a one-clock activity strobe into a visible indication. Per-channel modes: off, stretch, sticky latch, or blink-while-active.
- A power-on lamp test drives every LED on for a fixed time after reset.
- Sits between bus/status logic and the open-drain LED pins. Outputs are active high; the top level inverts them for the pins.

Parameters:
- NCH, 4, number of LED channels (1..16)
- TIMER_BITS, 8, width of each stretch timer; stretch length is 2^TIMER_BITS-1 ticks
- BLINK_TICKS, 25, ticks per blink half-period (>=1)
- LAMP_TICKS, 50, ticks of forced-on lamp test after reset (0 disables it)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- tick  in  1  one-clk timebase strobe, synchronous to clk (nominally 10 Hz)
- d  in  NCH  activity strobes, synchronous to clk, active high
- mode  in  2*NCH  per-channel mode; channel i uses mode[2i+1:2i]
- clr  in  NCH  per-channel clear of the latch bit, active high
- lamp_test  in  1  level; forces all q high while asserted
- q  out  NCH  LED drive, active high, registered
- lamp_active  out  1  high while the power-on lamp test runs, registered

Behaviour:
- Reset (nrst low, async):
  - q = all ones; lamp_active = 1; all timers = 0; all latch bits = 0.
  - blink_phase = 1; blink divider = 0; lamp counter = LAMP_TICKS.
  - If LAMP_TICKS = 0: lamp_active = 0, and q resets to all ones then follows normal rules from the first clock.
- Modes (shared package enum):
  - 0 OFF, 1 STRETCH, 2 LATCH, 3 BLINK.
- Per-channel timer (runs in every mode):
  - d[i] = 1 → timer = all ones.
  - Else if timer != 0 and tick → timer - 1.
  - Else hold.
  - d has priority over tick in the same cycle.
- Per-channel latch bit (runs in every mode):
  - d[i] = 1 → set.
  - Else if clr[i] → clear.
  - Simultaneous d and clr: set.
- Blink divider (shared by all channels):
  - Counts ticks 0..BLINK_TICKS-1.
  - On the tick that wraps it to 0, blink_phase toggles.
- Lamp counter:
  - Decrements on tick while nonzero.
  - lamp_active = (counter != 0), registered.
- Channel indication ind[i], from current (pre-update) register values:
  - OFF: 0.
  - STRETCH: timer != 0.
  - LATCH: latch bit.
  - BLINK: (timer != 0) & blink_phase.
- Output:
  - q[i] <= ind[i] | lamp_active | lamp_test, registered.
  - lamp_active here is the current registered value.
- Latency:
  - d[i] high at clock edge n → timer full after edge n → q[i] high after edge n+1 (two clocks from strobe sample).
  - lamp_test → q: one clock.
- Stretch length after the last d:
  - q stays high for 2^TIMER_BITS-1 ticks.
  - q falls one clock after the tick that brings the timer to 0.
- Repeated d while the timer is nonzero retriggers it to full. There is no saturation side effect.
- Mode change mid-operation:
  - Timers and latch bits are not disturbed.
  - The new mode is visible on q one clock after mode changes.
- The blink phase is global, so all BLINK channels flash in unison.
- d/clr on channels in OFF mode still update state.
- Reset asserted mid-stretch or mid-lamp-test: all state returns immediately to the reset values above.

Decomposition:
- Package led_pkg:
  - led_mode_t (2-bit enum OFF/STRETCH/LATCH/BLINK).
  - Default parameter constants.
  - Function for the channel-indication mux.
- Sub-module led_channel (TIMER_BITS param):
  - Holds the timer, latch bit and ind logic for one channel.
  - Instantiated NCH times in a generate loop.
- The blink divider, lamp counter and output register stay in the top level.

Test Plan:
- Reset/lamp test (LAMP_TICKS=3, tick every 10 clk): release nrst with no d → q=4'b1111 and lamp_active=1 until one clock after the 3rd tick, then q=4'b0000 and lamp_active=0.
- Stretch (TIMER_BITS=4, mode=STRETCH all, after lamp test):
  - 1-clk d[0] → q[0] rises 2 clk later and stays high for 15 ticks.
  - Second d[0] at tick 10 retriggers, giving 15 more ticks.
  - Strobe d and tick on the same clock → timer reloads to 15, not 14.
- Latch (ch1 mode=LATCH):
  - d[1] pulse → q[1]=1 indefinitely past 2^TIMER_BITS ticks.
  - clr[1] → q[1]=0 two clocks later.
  - d[1] and clr[1] on the same clock → q[1] stays 1.
- Blink (ch2 BLINK, ch3 BLINK, BLINK_TICKS=2):
  - d[2] and d[3] on different clocks → both toggle in unison every 2 ticks while the timer is nonzero.
  - q = 0 after the timer expires, regardless of blink_phase.
- Mode switch and overrides:
  - Ch0 in STRETCH with timer=8, switch to OFF → q[0]=0 next clk; switch back at timer=5 → q[0]=1 next clk.
  - lamp_test=1 → q=4'b1111 next clk.
- Async reset mid-stretch: assert nrst while timers are nonzero → q=1111 immediately (no clk edge), timers=0; after the lamp test, q=0000.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the front-panel LED indicator bank.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_STRETCH = 2'd1,
      MODE_LATCH   = 2'd2,
      MODE_BLINK   = 2'd3
   } led_mode_t;

   localparam int NCH_DEF         = 4;
   localparam int TIMER_BITS_DEF  = 8;
   localparam int BLINK_TICKS_DEF = 25;
   localparam int LAMP_TICKS_DEF  = 50;

   function automatic logic led_ind(
      input led_mode_t m,
      input logic      run,
      input logic      latch,
      input logic      phase
   );
      logic ind;
      ind = 1'b0;
      unique case (m)
         MODE_OFF:     ind = 1'b0;
         MODE_STRETCH: ind = run;
         MODE_LATCH:   ind = latch;
         MODE_BLINK:   ind = run & phase;
      endcase
      return ind;
   endfunction

endpackage

// File: rtl/led_indicator_bank_channel.sv
// One indicator channel: stretch timer, sticky latch and indication mux.
module led_channel
   import led_pkg::*;
#(
   parameter int TIMER_BITS = TIMER_BITS_DEF
) (
   input  logic      clk,
   input  logic      nrst,
   input  logic      tick_i,
   input  logic      d_i,
   input  logic      clr_i,
   input  led_mode_t mode_i,
   input  logic      phase_i,
   output logic      ind_o
);

   logic [TIMER_BITS-1:0] timer_q, timer_d;
   logic                  latch_q, latch_d;

   // A strobe always reloads, even on a tick cycle.
   always_comb begin
      timer_d = timer_q;
      if (d_i) begin
         timer_d = '1;
      end else if (tick_i && timer_q != '0) begin
         timer_d = timer_q - TIMER_BITS'(1);
      end
   end

   always_comb begin
      latch_d = latch_q;
      if (d_i) begin
         latch_d = 1'b1;
      end else if (clr_i) begin
         latch_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         timer_q <= '0;
         latch_q <= 1'b0;
      end else begin
         timer_q <= timer_d;
         latch_q <= latch_d;
      end
   end

   assign ind_o = led_ind(mode_i, timer_q != '0, latch_q, phase_i);

endmodule

// File: rtl/led_indicator_bank.sv
// Multi-channel LED indicator driver with shared blink timebase and
// power-on lamp test.
module led_indicator_bank
   import led_pkg::*;
#(
   parameter int NCH         = NCH_DEF,
   parameter int TIMER_BITS  = TIMER_BITS_DEF,
   parameter int BLINK_TICKS = BLINK_TICKS_DEF,
   parameter int LAMP_TICKS  = LAMP_TICKS_DEF
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             tick,
   input  logic [NCH-1:0]   d,
   input  logic [2*NCH-1:0] mode,
   input  logic [NCH-1:0]   clr,
   input  logic             lamp_test,
   output logic [NCH-1:0]   q,
   output logic             lamp_active
);

   localparam int DIV_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int LAMP_W = (LAMP_TICKS > 0) ? $clog2(LAMP_TICKS + 1) : 1;

   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(BLINK_TICKS - 1);
   localparam logic [LAMP_W-1:0] LAMP_RST = LAMP_W'(LAMP_TICKS);
   localparam logic              LAMP_ON  = (LAMP_TICKS != 0);

   logic [DIV_W-1:0]  div_q, div_d;
   logic              phase_q, phase_d;
   logic [LAMP_W-1:0] lamp_cnt_q, lamp_cnt_d;
   logic              lamp_act_q;
   logic [NCH-1:0]    q_q, ind;

   genvar i;
   for (i = 0; i < NCH; i++) begin : g_ch
      led_channel #(
         .TIMER_BITS(TIMER_BITS)
      ) u_ch (
         .clk    (clk),
         .nrst   (nrst),
         .tick_i (tick),
         .d_i    (d[i]),
         .clr_i  (clr[i]),
         .mode_i (led_mode_t'(mode[2*i +: 2])),
         .phase_i(phase_q),
         .ind_o  (ind[i])
      );
   end

   always_comb begin
      div_d   = div_q;
      phase_d = phase_q;
      if (tick) begin
         if (div_q == DIV_MAX) begin
            div_d   = '0;
            phase_d = ~phase_q;
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end
   end

   always_comb begin
      lamp_cnt_d = lamp_cnt_q;
      if (tick && lamp_cnt_q != '0) begin
         lamp_cnt_d = lamp_cnt_q - LAMP_W'(1);
      end
   end

   // lamp_active tracks the counter in the same edge it reaches zero.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         div_q      <= '0;
         phase_q    <= 1'b1;
         lamp_cnt_q <= LAMP_RST;
         lamp_act_q <= LAMP_ON;
         q_q        <= '1;
      end else begin
         div_q      <= div_d;
         phase_q    <= phase_d;
         lamp_cnt_q <= lamp_cnt_d;
         lamp_act_q <= (lamp_cnt_d != '0);
         q_q        <= ind | {NCH{lamp_act_q}} | {NCH{lamp_test}};
      end
   end

   assign q           = q_q;
   assign lamp_active = lamp_act_q;

endmodule
